// File: rtl/bcd_count_7.sv
// ============================================================================
// Module      : bcd_count_7
// Description : Two-digit BCD up-counter with a run-time terminal count.
//               Optional wrap-around at the limit via BCD_COUNT_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_count_7 (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] max_count,
    input  logic       run,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2
);

    localparam logic [6:0] C_MAX_LIMIT = 7'd99;
    localparam logic [3:0] C_DIGIT_MAX = 4'd9;

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [6:0] limit_q, limit_d;

    logic [6:0] w_limit_clamped;
    logic [6:0] w_count_bin;
    logic       w_at_limit;

    assign w_limit_clamped = (max_count > C_MAX_LIMIT) ? C_MAX_LIMIT : max_count;

    // 10*tens + ones, built from shifts; at most 99 so 7 bits suffice
    assign w_count_bin = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1)
                       + {3'b000, ones_q};
    assign w_at_limit  = (w_count_bin == limit_q);

    always_comb begin
        ones_d  = ones_q;
        tens_d  = tens_q;
        limit_d = limit_q;
        if (!run) begin
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            limit_d = w_limit_clamped;
        end else if (w_at_limit) begin
`ifdef BCD_COUNT_WRAP_EN
            ones_d = 4'd0;
            tens_d = 4'd0;
`else
            ones_d = ones_q;
            tens_d = tens_q;
`endif
        end else if (ones_q == C_DIGIT_MAX) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
        end else begin
            ones_d = ones_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            limit_q <= 7'd0;
        end else begin
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            limit_q <= limit_d;
        end
    end

    assign digit_1 = ones_q;
    assign digit_2 = tens_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_count_7.sv
// ============================================================================
// Module      : tb_bcd_count_7
// Description : Scoreboard bench for bcd_count_7 against a binary count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_count_7;

    logic       clk;
    logic       rst_n;
    logic [6:0] max_count;
    logic       run;
    logic [3:0] digit_1;
    logic [3:0] digit_2;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt = 0;
    int m_lim = 0;

    logic [7:0] exp_q[$];

    bcd_count_7 u_dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .max_count (max_count),
        .run       (run),
        .digit_1   (digit_1),
        .digit_2   (digit_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one edge worth of inputs, advance the model, compare after the edge
    task automatic step(input string tag, input logic r_n, input logic rn, input logic [6:0] mc);
        logic [7:0] expv;
        rst_n     = r_n;
        run       = rn;
        max_count = mc;
        if (!r_n) begin
            m_cnt = 0;
            m_lim = 0;
        end else if (!rn) begin
            m_cnt = 0;
            m_lim = (int'(mc) > 99) ? 99 : int'(mc);
        end else if (m_cnt == m_lim) begin
`ifdef BCD_COUNT_WRAP_EN
            m_cnt = 0;
`endif
        end else begin
            m_cnt = m_cnt + 1;
        end
        expv[7:4] = 4'(m_cnt / 10);
        expv[3:0] = 4'(m_cnt % 10);
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check(tag, {digit_2, digit_1}, exp_q.pop_front());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b1;
        max_count = 7'd50;

        repeat (2) step("reset", 1'b0, 1'b1, 7'd50);
        repeat (4) step("post_reset_lim0", 1'b1, 1'b1, 7'd50);

        step("load73", 1'b1, 1'b0, 7'd73);
        for (int i = 0; i < 100; i++)
            step("count73", 1'b1, 1'b1, (i < 30) ? 7'd73 : 7'd15);

        repeat (2) step("load15", 1'b1, 1'b0, 7'd15);
        repeat (20) step("count15", 1'b1, 1'b1, 7'd15);

        repeat (5) step("ignore118", 1'b1, 1'b1, 7'd118);
        repeat (2) step("load118", 1'b1, 1'b0, 7'd118);
        repeat (105) step("count99", 1'b1, 1'b1, 7'd118);

        step("load99", 1'b1, 1'b0, 7'd99);
        repeat (12) step("pre_rst", 1'b1, 1'b1, 7'd99);
        step("mid_rst", 1'b0, 1'b1, 7'd99);
        repeat (5) step("after_rst", 1'b1, 1'b1, 7'd99);

        step("pulse5", 1'b1, 1'b0, 7'd5);
        repeat (14) step("count5", 1'b1, 1'b1, 7'd5);

        step("load0", 1'b1, 1'b0, 7'd0);
        repeat (4) step("count0", 1'b1, 1'b1, 7'd0);

        for (int i = 0; i < 300; i++) begin
            logic       r_n;
            logic       rn;
            logic [6:0] mc;
            r_n = ($urandom_range(0, 39) != 0);
            rn  = ($urandom_range(0, 9) != 0);
            mc  = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) mc = 7'($urandom_range(0, 12));
            step("random", r_n, rn, mc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
